// File: rtl/tcdm_mux.sv
// N-to-1 TCDM request multiplexer with round-robin arbitration, a lock that holds an
// ungranted request on the bank, and an in-order routing FIFO for read responses.
module tcdm_mux #(
    parameter int unsigned NR_INPUTS       = 2,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,

    // upstream master ports (one lane per demux output)
    input  logic [NR_INPUTS-1:0]                   master_req,
    output logic [NR_INPUTS-1:0]                   master_gnt,
    input  logic [NR_INPUTS-1:0][ADDR_WIDTH-1:0]   master_addr,
    input  logic [NR_INPUTS-1:0]                   master_wen,
    input  logic [NR_INPUTS-1:0][DATA_WIDTH-1:0]   master_data,
    input  logic [NR_INPUTS-1:0][BE_WIDTH-1:0]     master_be,
    output logic [NR_INPUTS-1:0]                   master_r_valid,
    input  logic [NR_INPUTS-1:0]                   master_r_ready,
    output logic [NR_INPUTS-1:0][DATA_WIDTH-1:0]   master_r_data,

    // downstream memory bank port
    output logic                                   slave_req,
    input  logic                                   slave_gnt,
    output logic [ADDR_WIDTH-1:0]                  slave_addr,
    output logic                                   slave_wen,
    output logic [DATA_WIDTH-1:0]                  slave_data,
    output logic [BE_WIDTH-1:0]                    slave_be,
    input  logic                                   slave_r_valid,
    output logic                                   slave_r_ready,
    input  logic [DATA_WIDTH-1:0]                  slave_r_data
);

    localparam int unsigned IDX_W  = $clog2(NR_INPUTS);
    localparam int unsigned CAND_W = IDX_W + 1;
    localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

    // arbitration state
    logic [IDX_W-1:0]  rr_q;
    logic              lock_q;
    logic [IDX_W-1:0]  lock_idx_q;

    // response routing FIFO
    logic [IDX_W-1:0]  route_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic [NR_INPUTS-1:0] eligible;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     rr_next;
    logic [CAND_W-1:0]    cand;
    logic                 found;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [IDX_W-1:0]     head;
    logic                 grant;
    logic                 push;
    logic                 pop;

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head       = route_mem[rd_ptr_q];

    // Reads stall while the routing FIFO is full, even if it drains this cycle.
    generate
        for (genvar gi = 0; gi < NR_INPUTS; gi++) begin : g_elig
            assign eligible[gi] = master_req[gi] & (master_wen[gi] | ~fifo_full);
        end
    endgenerate

    always_comb begin
        winner = lock_idx_q;
        found  = 1'b0;
        cand   = '0;
        if (lock_q) begin
            found = eligible[lock_idx_q];
        end else begin
            winner = rr_q;
            for (int k = 0; k < NR_INPUTS; k++) begin
                cand = {1'b0, rr_q} + CAND_W'(k);
                if (cand >= CAND_W'(NR_INPUTS)) begin
                    cand = cand - CAND_W'(NR_INPUTS);
                end
                if (!found && eligible[cand[IDX_W-1:0]]) begin
                    found  = 1'b1;
                    winner = cand[IDX_W-1:0];
                end
            end
        end
    end

    assign rr_next = (winner == IDX_W'(NR_INPUTS - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        slave_req  = 1'b0;
        slave_addr = '0;
        slave_wen  = 1'b1;
        slave_data = '0;
        slave_be   = '0;
        if (found) begin
            slave_req  = 1'b1;
            slave_addr = master_addr[winner];
            slave_wen  = master_wen[winner];
            slave_data = master_data[winner];
            slave_be   = master_be[winner];
        end
    end

    assign grant         = slave_req & slave_gnt;
    assign push          = grant & ~slave_wen;
    assign slave_r_ready = ~fifo_empty & master_r_ready[head];
    assign pop           = slave_r_valid & slave_r_ready;

    // Grant and response steering, zero cycles in both directions.
    generate
        for (genvar gi = 0; gi < NR_INPUTS; gi++) begin : g_route
            logic is_head;
            assign is_head            = ~fifo_empty & (head == IDX_W'(gi));
            assign master_gnt[gi]     = found & (winner == IDX_W'(gi)) & slave_gnt;
            assign master_r_valid[gi] = is_head & slave_r_valid;
            assign master_r_data[gi]  = is_head ? slave_r_data : '0;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (grant) begin
            rr_q   <= rr_next;
            lock_q <= 1'b0;
        end else if (slave_req) begin
            // Hold the stalled request on the bank until the memory accepts it.
            lock_q     <= 1'b1;
            lock_idx_q <= winner;
        end else begin
            lock_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Entries are only read while counted, so the storage itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            route_mem[wr_ptr_q] <= winner;
        end
    end

endmodule

// File: tb/tb_tcdm_mux.sv
// Directed scenarios plus a randomized run of tcdm_mux against a queue-based reference model.
module tb_tcdm_mux;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int AW = 32;
    localparam int MO = 2;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                 rst_i;
    logic [N-1:0]         m_req, m_gnt, m_wen, m_rvalid, m_rready;
    logic [N-1:0][AW-1:0] m_addr;
    logic [N-1:0][DW-1:0] m_data, m_rdata;
    logic [N-1:0][BW-1:0] m_be;
    logic                 s_req, s_gnt, s_wen, s_rvalid, s_rready;
    logic [AW-1:0]        s_addr;
    logic [DW-1:0]        s_data, s_rdata;
    logic [BW-1:0]        s_be;

    tcdm_mux #(
        .NR_INPUTS(N), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .master_req(m_req), .master_gnt(m_gnt), .master_addr(m_addr), .master_wen(m_wen),
        .master_data(m_data), .master_be(m_be), .master_r_valid(m_rvalid),
        .master_r_ready(m_rready), .master_r_data(m_rdata),
        .slave_req(s_req), .slave_gnt(s_gnt), .slave_addr(s_addr), .slave_wen(s_wen),
        .slave_data(s_data), .slave_be(s_be), .slave_r_valid(s_rvalid),
        .slave_r_ready(s_rready), .slave_r_data(s_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: priority pointer, lock, and a queue of masters awaiting responses
    int  mdl_rr;
    bit  mdl_lock;
    int  mdl_lock_idx;
    int  route_q[$];

    int                   exp_winner;
    logic [N-1:0]         exp_gnt, exp_rvalid;
    logic [N-1:0][DW-1:0] exp_rdata;
    logic                 exp_srready;
    logic [69:0]          exp_sbundle;

    function automatic bit mdl_elig(int i);
        return m_req[i] && (m_wen[i] || route_q.size() < MO);
    endfunction

    task automatic model_reset();
        mdl_rr = 0;
        mdl_lock = 0;
        mdl_lock_idx = 0;
        route_q.delete();
    endtask

    task automatic model_eval();
        int w;
        w = -1;
        if (mdl_lock) begin
            if (mdl_elig(mdl_lock_idx)) w = mdl_lock_idx;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && mdl_elig((mdl_rr + k) % N)) w = (mdl_rr + k) % N;
            end
        end
        exp_winner  = w;
        exp_gnt     = '0;
        exp_sbundle = {1'b0, {AW{1'b0}}, 1'b1, {DW{1'b0}}, {BW{1'b0}}};
        if (w >= 0) begin
            exp_sbundle = {1'b1, m_addr[w], m_wen[w], m_data[w], m_be[w]};
            exp_gnt[w]  = s_gnt;
        end
        exp_rvalid  = '0;
        exp_rdata   = '0;
        exp_srready = 1'b0;
        if (route_q.size() > 0) begin
            exp_rvalid[route_q[0]] = s_rvalid;
            exp_rdata[route_q[0]]  = s_rdata;
            exp_srready            = m_rready[route_q[0]];
        end
    endtask

    task automatic model_commit();
        bit do_pop, do_push;
        do_pop  = route_q.size() > 0 && s_rvalid && m_rready[route_q[0]];
        do_push = 0;
        if (exp_winner >= 0 && s_gnt) begin
            mdl_rr   = (exp_winner + 1) % N;
            mdl_lock = 0;
            do_push  = !m_wen[exp_winner];
        end else if (exp_winner >= 0) begin
            mdl_lock     = 1;
            mdl_lock_idx = exp_winner;
        end else begin
            mdl_lock = 0;
        end
        if (do_pop) void'(route_q.pop_front());
        if (do_push) route_q.push_back(exp_winner);
    endtask

    task automatic idle_inputs();
        m_req = '0; m_wen = '0; m_rready = '0;
        m_addr = '0; m_data = '0; m_be = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    endtask

    task automatic tick();
        model_eval();
        if (exp_winner >= 0 && s_gnt)
            $display("txn grant m%0d %s addr=%h", exp_winner, m_wen[exp_winner] ? "wr" : "rd", m_addr[exp_winner]);
        if (route_q.size() > 0 && s_rvalid && m_rready[route_q[0]])
            $display("txn resp  m%0d data=%h", route_q[0], s_rdata);
        @(posedge clk_i);
        if (!rst_i) model_commit();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle_inputs();
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; m_rready = '1;
        model_reset();
        @(negedge clk_i);
        #1;
        n_checks++;
        if ({s_req, s_wen, s_addr, s_data, s_be} !== {1'b0, 1'b1, 68'h0}) begin
            n_fail++; $display("FAIL reset_slave_req: got req=%b wen=%b addr=%h want req=0 wen=1 addr=0", s_req, s_wen, s_addr);
        end
        n_checks++;
        if (m_gnt !== 2'b00 || m_rvalid !== 2'b00) begin
            n_fail++; $display("FAIL reset_master_out: got gnt=%b rvalid=%b want 00 00", m_gnt, m_rvalid);
        end
        n_checks++;
        if (s_rready !== 1'b0 || m_rdata !== '0) begin
            n_fail++; $display("FAIL reset_rready: got rready=%b rdata=%h want 0 0", s_rready, m_rdata);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        idle_inputs();
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        m_req = 2'b11; m_wen = 2'b00; m_addr[0] = 32'h100; m_addr[1] = 32'h200;
        s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h1111_0000; m_rready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if (m_gnt !== want) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, m_gnt, want);
            end
            want = (i == 0) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
            n_checks++;
            if (m_rvalid !== want) begin
                n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, m_rvalid, want);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        m_addr[0] = 32'hA000_0000; m_addr[1] = 32'hB000_0001;
        m_req = 2'b10; m_wen = 2'b00; s_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) m_req = 2'b11;
            if (i == 3) s_gnt = 1'b1;
            #1;
            n_checks++;
            if (i < 4 && (s_req !== 1'b1 || s_addr !== 32'hB000_0001)) begin
                n_fail++; $display("FAIL lock_hold[%0d]: got req=%b addr=%h want 1 b0000001", i, s_req, s_addr);
            end else if (i == 4 && (s_addr !== 32'hA000_0000 || m_gnt !== 2'b01)) begin
                n_fail++; $display("FAIL lock_next[%0d]: got addr=%h gnt=%b want a0000000 01", i, s_addr, m_gnt);
            end else if (i < 3 && m_gnt !== 2'b00) begin
                n_fail++; $display("FAIL lock_stall_gnt[%0d]: got %b want 00", i, m_gnt);
            end else if (i == 3 && m_gnt !== 2'b10) begin
                n_fail++; $display("FAIL lock_grant[%0d]: got %b want 10", i, m_gnt);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        do_reset();
        m_addr[0] = 32'h10; m_addr[1] = 32'h20; s_gnt = 1'b1; m_wen = 2'b00;
        m_req = 2'b01; #1;
        n_checks++;
        if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL full_rd0: got %b want 01", m_gnt); end
        tick();
        m_req = 2'b10; #1;
        n_checks++;
        if (m_gnt !== 2'b10) begin n_fail++; $display("FAIL full_rd1: got %b want 10", m_gnt); end
        tick();
        m_req = 2'b01; #1;
        n_checks++;
        if (s_req !== 1'b0 || m_gnt !== 2'b00) begin
            n_fail++; $display("FAIL full_block_rd: got req=%b gnt=%b want 0 00", s_req, m_gnt);
        end
        tick();
        m_req = 2'b11; m_wen = 2'b10; m_data[1] = 32'hCAFE_F00D; #1;
        n_checks++;
        if (m_gnt !== 2'b10 || s_wen !== 1'b1 || s_data !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL full_write: got gnt=%b wen=%b data=%h want 10 1 cafef00d", m_gnt, s_wen, s_data);
        end
        tick();
        m_req = 2'b01; #1;
        n_checks++;
        if (s_req !== 1'b0) begin n_fail++; $display("FAIL full_after_wr: got req=%b want 0", s_req); end
        tick();
        idle_inputs();
    endtask

    task automatic test_response_order();
        do_reset();
        s_gnt = 1'b1; m_wen = 2'b00;
        m_req = 2'b01; tick();
        m_req = 2'b10; tick();
        m_req = 2'b00; m_rready = 2'b11; s_rvalid = 1'b1; s_rdata = 32'hA5A5_A5A5; #1;
        n_checks++;
        if (m_rvalid !== 2'b01 || m_rdata[0] !== 32'hA5A5_A5A5 || m_rdata[1] !== 32'h0 || s_rready !== 1'b1) begin
            n_fail++; $display("FAIL resp_first: got rvalid=%b d0=%h d1=%h rr=%b want 01 a5a5a5a5 0 1", m_rvalid, m_rdata[0], m_rdata[1], s_rready);
        end
        tick();
        s_rdata = 32'h5A5A_5A5A; #1;
        n_checks++;
        if (m_rvalid !== 2'b10 || m_rdata[1] !== 32'h5A5A_5A5A || m_rdata[0] !== 32'h0) begin
            n_fail++; $display("FAIL resp_second: got rvalid=%b d0=%h d1=%h want 10 0 5a5a5a5a", m_rvalid, m_rdata[0], m_rdata[1]);
        end
        tick();
        s_rdata = 32'h1234_5678; #1;
        n_checks++;
        if (m_rvalid !== 2'b00 || s_rready !== 1'b0) begin
            n_fail++; $display("FAIL resp_stray: got rvalid=%b rready=%b want 00 0", m_rvalid, s_rready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        s_gnt = 1'b1; m_req = 2'b01; m_wen = 2'b00; tick();
        m_req = 2'b00; s_rvalid = 1'b1; s_rdata = 32'hC3C3_3C3C; m_rready = 2'b00;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (s_rready !== 1'b0 || m_rvalid !== 2'b01 || m_rdata[0] !== 32'hC3C3_3C3C) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got rready=%b rvalid=%b d0=%h want 0 01 c3c33c3c", i, s_rready, m_rvalid, m_rdata[0]);
            end
            tick();
        end
        m_rready = 2'b01; #1;
        n_checks++;
        if (s_rready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got rready=%b want 1", s_rready); end
        tick();
        #1;
        n_checks++;
        if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL bp_popped: got rvalid=%b want 00", m_rvalid); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        s_gnt = 1'b1; m_req = 2'b01; m_wen = 2'b00; tick();
        s_gnt = 1'b0; m_req = 2'b10; tick();
        rst_i = 1'b1;
        idle_inputs();
        model_reset();
        s_rvalid = 1'b1; m_rready = 2'b11; #1;
        n_checks++;
        if (m_gnt !== 2'b00 || m_rvalid !== 2'b00 || s_rready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_during: got gnt=%b rvalid=%b rready=%b want 00 00 0", m_gnt, m_rvalid, s_rready);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        m_req = 2'b11; m_wen = 2'b00; s_gnt = 1'b1; #1;
        n_checks++;
        if (m_gnt !== 2'b01 || m_rvalid !== 2'b00 || s_rready !== 1'b0) begin
            n_fail++; $display("FAIL midrst_after: got gnt=%b rvalid=%b rready=%b want 01 00 0", m_gnt, m_rvalid, s_rready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 200) do_reset();
            for (int i = 0; i < N; i++) begin
                // a master keeps its request stable until it is granted
                if (!(m_req[i] && !exp_gnt[i])) begin
                    m_req[i]  = ($urandom_range(0, 1) == 1);
                    m_wen[i]  = ($urandom_range(0, 1) == 1);
                    m_addr[i] = $urandom;
                    m_data[i] = $urandom;
                    m_be[i]   = 4'($urandom);
                end
                m_rready[i] = ($urandom_range(0, 3) != 0);
            end
            s_gnt    = ($urandom_range(0, 3) != 0);
            s_rvalid = ($urandom_range(0, 1) == 1);
            s_rdata  = $urandom;
            #1;
            model_eval();
            n_checks++;
            if (m_gnt !== exp_gnt) begin
                n_fail++; $display("FAIL rand_gnt[%0d]: got %b want %b", cyc, m_gnt, exp_gnt);
            end
            n_checks++;
            if ({s_req, s_addr, s_wen, s_data, s_be} !== exp_sbundle) begin
                n_fail++; $display("FAIL rand_slave[%0d]: got %h want %h", cyc, {s_req, s_addr, s_wen, s_data, s_be}, exp_sbundle);
            end
            n_checks++;
            if (m_rvalid !== exp_rvalid) begin
                n_fail++; $display("FAIL rand_rvalid[%0d]: got %b want %b", cyc, m_rvalid, exp_rvalid);
            end
            n_checks++;
            if (m_rdata !== exp_rdata) begin
                n_fail++; $display("FAIL rand_rdata[%0d]: got %h want %h", cyc, m_rdata, exp_rdata);
            end
            n_checks++;
            if (s_rready !== exp_srready) begin
                n_fail++; $display("FAIL rand_rready[%0d]: got %b want %b", cyc, s_rready, exp_srready);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        exp_gnt = '0;
        test_reset();
        test_round_robin();
        test_lock();
        test_fifo_full();
        test_response_order();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
